// File: rtl/tdm_channel_link.sv
// tdm_channel_link: time-division multiplexes CH input channels over one
// registered link word and distributes each word to a registered per-channel
// output slice. The link runs either as a round-robin scan or on a fixed
// channel. Optional feature macro: PARITY_CHECK_EN. It adds an even-parity bit
// to the link word, an err_inject test hook and a parity_err pulse output.
module tdm_channel_link #(
  parameter int CH = 8,
  parameter int DW = 8,
  localparam int AW = $clog2(CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [AW-1:0]    sel,
  input  logic [CH*DW-1:0] iData,
`ifdef PARITY_CHECK_EN
  input  logic             err_inject,
  output logic             parity_err,
`endif
  output logic [CH*DW-1:0] oData,
  output logic [CH-1:0]    o_valid,
  output logic             frame_done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FIXED = 2'd2} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(CH - 1);
  localparam logic [AW:0]   CH_LIM    = (AW + 1)'(CH);
  localparam bit            POW2      = ((1 << AW) == CH);

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic evenParity(input logic [DW-1:0] d);
    return ^d;
  endfunction

  state_t        state_r, stateNext_s;
  logic [AW-1:0] ptr_r, ptrNext_s;
  logic          issue_s, wrap_s, selOk_s, parOk_s;
  logic [AW-1:0] issueAddr_s;
  logic [DW-1:0] issueData_s;
  logic          linkVld_r;
  logic [AW-1:0] linkAddr_r;
  logic [DW-1:0] linkData_r;
`ifdef PARITY_CHECK_EN
  logic          linkPar_r;
`endif

  // With a power-of-two channel count every sel value names a real channel.
  generate
    if (POW2) begin : gSelAll
      assign selOk_s = 1'b1;
    end else begin : gSelRange
      assign selOk_s = ({1'b0, sel} < CH_LIM);
    end
  endgenerate

  // Next state, issue decision, issued channel and next scan pointer.
  always_comb begin
    stateNext_s = IDLE;
    issue_s     = 1'b0;
    issueAddr_s = '0;
    wrap_s      = 1'b0;
    ptrNext_s   = ptr_r;
    if (!en) begin
      stateNext_s = IDLE;
    end else if (mode) begin
      stateNext_s = SCAN;
    end else begin
      stateNext_s = FIXED;
    end
    case (stateNext_s)
      SCAN: begin
        issue_s = 1'b1;
        if (state_r == SCAN) begin
          issueAddr_s = ptr_r;
        end else begin
          issueAddr_s = '0;
        end
        wrap_s = (issueAddr_s == LAST_ADDR);
        if (wrap_s) begin
          ptrNext_s = '0;
        end else begin
          ptrNext_s = issueAddr_s + AW'(1);
        end
      end
      FIXED: begin
        if (selOk_s) begin
          issue_s     = 1'b1;
          issueAddr_s = sel;
        end else begin
          issue_s = 1'b0;
        end
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
  end

  // Slice mux for the issued channel.
  always_comb begin
    issueData_s = '0;
    for (int k = 0; k < CH; k++) begin
      if (issueAddr_s == AW'(k)) begin
        issueData_s = iData[k*DW +: DW];
      end else begin
        issueData_s = issueData_s;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  assign parOk_s = (evenParity(linkData_r) == linkPar_r);
`else
  assign parOk_s = 1'b1;
`endif

  // FSM state and scan pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= '0;
    end else begin
      state_r <= stateNext_s;
      ptr_r   <= ptrNext_s;
    end
  end

  // Stage 1: capture the issued word into the link register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      linkVld_r  <= 1'b0;
      linkAddr_r <= '0;
      linkData_r <= '0;
`ifdef PARITY_CHECK_EN
      linkPar_r  <= 1'b0;
`endif
    end else begin
      linkVld_r <= issue_s;
      if (issue_s) begin
        linkAddr_r <= issueAddr_s;
        linkData_r <= issueData_s;
`ifdef PARITY_CHECK_EN
        linkPar_r  <= evenParity(issueData_s) ^ err_inject;
`endif
      end else begin
        linkAddr_r <= linkAddr_r;
      end
    end
  end

  // Stage 2: deliver the link word to its channel slice; only that slice moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oData      <= '1;
      o_valid    <= '0;
      frame_done <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_done <= issue_s && (stateNext_s == SCAN) && wrap_s;
`ifdef PARITY_CHECK_EN
      parity_err <= linkVld_r && !parOk_s;
`endif
      for (int k = 0; k < CH; k++) begin
        if (linkVld_r && parOk_s && (linkAddr_r == AW'(k))) begin
          oData[k*DW +: DW] <= linkData_r;
          o_valid[k]        <= 1'b1;
        end else begin
          o_valid[k]        <= 1'b0;
        end
      end
    end
  end

  assign busy = linkVld_r;

endmodule

// File: tb/tb_tdm_channel_link.sv
// Self-checking bench for tdm_channel_link (CH=8, DW=8). A channel-level model
// (expected slice array, one pending word, a "currently scanning" flag and the
// next scan channel) predicts every output after each clock edge. Directed
// sequences pin the model to hand-computed literals; random traffic follows.
module tb_tdm_channel_link;
  localparam int CH = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          mode = 1'b0;
  logic [2:0]    sel = 3'd0;
  logic [63:0]   iData = 64'd0;
  logic [63:0]   oData;
  logic [7:0]    o_valid;
  logic          frame_done;
  logic          busy;
`ifdef PARITY_CHECK_EN
  logic          errInject = 1'b0;
  logic          parityErr;
`endif

  tdm_channel_link #(.CH(CH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .iData(iData),
`ifdef PARITY_CHECK_EN
    .err_inject(errInject), .parity_err(parityErr),
`endif
    .oData(oData), .o_valid(o_valid), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model state
  logic [7:0] expSlice[CH];
  bit         pendV;
  int         pendA;
  logic [7:0] pendD;
  bit         pendBad;
  bit         scanning;
  int         nextCh;
  logic [7:0] expValid;
  bit         expFrame;
  bit         expPerr;
  int         framesSeen;

  function automatic logic [63:0] expBus();
    logic [63:0] b;
    for (int k = 0; k < CH; k++) b[k*8 +: 8] = expSlice[k];
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < CH; k++) expSlice[k] = 8'hFF;
    pendV = 1'b0; pendA = 0; pendD = 8'h00; pendBad = 1'b0;
    scanning = 1'b0; nextCh = 0;
    expValid = 8'h00; expFrame = 1'b0; expPerr = 1'b0;
  endtask

  task automatic compareAll();
    check("oData", oData, expBus());
    check("o_valid", {56'd0, o_valid}, {56'd0, expValid});
    check("frame_done", {63'd0, frame_done}, {63'd0, expFrame});
    check("busy", {63'd0, busy}, {63'd0, pendV});
`ifdef PARITY_CHECK_EN
    check("parity_err", {63'd0, parityErr}, {63'd0, expPerr});
`endif
  endtask

  // Drive one cycle of inputs (called at a falling edge), predict, clock, compare.
  task automatic step(input bit e, input bit m, input int s, input logic [63:0] d, input bit inj);
    int a;
    bit iss;
    en = e; mode = m; sel = 3'(s); iData = d;
`ifdef PARITY_CHECK_EN
    errInject = inj;
`endif
    expValid = 8'h00; expPerr = 1'b0; expFrame = 1'b0;
    if (pendV) begin
      if (pendBad) expPerr = 1'b1;
      else begin
        expSlice[pendA] = pendD;
        expValid[pendA] = 1'b1;
      end
    end
    iss = 1'b0; a = 0;
    if (e && m) begin
      a = scanning ? nextCh : 0;
      nextCh = (a + 1) % CH;
      scanning = 1'b1;
      expFrame = (a == CH - 1);
      iss = 1'b1;
    end else if (e) begin
      scanning = 1'b0;
      a = s;
      iss = (s < CH);
    end else begin
      scanning = 1'b0;
    end
    pendV = iss; pendA = a; pendD = d[a*8 +: 8];
`ifdef PARITY_CHECK_EN
    pendBad = iss && inj;
`else
    pendBad = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    compareAll();
    if (frame_done) framesSeen++;
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic asyncReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [63:0] rampData;
  logic [63:0] a5Data;

  initial begin
    rampData = 64'h0807_0605_0403_0201;
    a5Data   = 64'h0000_5A00_0000_0000 | 64'h0000_A500_0000_0000;
    modelReset();
    framesSeen = 0;
    @(negedge clk);
    #1;
    check("reset oData", oData, 64'hFFFF_FFFF_FFFF_FFFF);
    check("reset o_valid", {56'd0, o_valid}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed mode, sel=5
    a5Data = 64'h1122_A544_5566_7788;
    step(1'b1, 1'b0, 5, a5Data, 1'b0);
    check("fixed first edge", oData, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 1'b0, 5, a5Data, 1'b0);
    check("fixed ch5", oData, 64'hFFFF_A5FF_FFFF_FFFF);
    check("fixed o_valid", {56'd0, o_valid}, 64'h20);
    step(1'b1, 1'b0, 5, a5Data, 1'b0);
    check("fixed o_valid again", {56'd0, o_valid}, 64'h20);

    // Auto scan from reset, ch k = k+1
    asyncReset();
    framesSeen = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 0, rampData, 1'b0);
      if (i >= 1) check("scan walk", {56'd0, o_valid}, 64'd1 << (i - 1));
    end
    check("scan all slices", oData, 64'h0807_0605_0403_0201);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 0, rampData, 1'b0);
    check("frame pulses", 64'(framesSeen), 64'd2);

    // Drop en at ptr=3
    asyncReset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 0, rampData, 1'b0);
    step(1'b0, 1'b1, 0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    check("drain ch3", {56'd0, o_valid}, 64'h08);
    check("drain busy", {63'd0, busy}, 64'd0);
    check("drain data", oData, 64'hFFFF_FFFF_0403_0201);
    step(1'b0, 1'b1, 0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    check("frozen", oData, 64'hFFFF_FFFF_0403_0201);
    step(1'b1, 1'b1, 0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    step(1'b1, 1'b1, 0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0);
    check("restart ch0", {56'd0, o_valid}, 64'h01);

    // Async reset at ptr=4, then no stale ch4 write
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0, rampData, 1'b0);
    asyncReset();
    step(1'b0, 1'b0, 0, rampData, 1'b0);
    step(1'b0, 1'b0, 0, rampData, 1'b0);
    check("no stale write", oData, 64'hFFFF_FFFF_FFFF_FFFF);

`ifdef PARITY_CHECK_EN
    step(1'b1, 1'b0, 2, 64'h0000_0000_0033_0000, 1'b1);
    step(1'b1, 1'b0, 2, 64'h0000_0000_0044_0000, 1'b0);
    check("perr pulse", {63'd0, parityErr}, 64'd1);
    check("perr no valid", {56'd0, o_valid}, 64'd0);
    step(1'b0, 1'b0, 2, 64'd0, 1'b0);
    check("perr next ok", oData, 64'hFFFF_FFFF_FF44_FFFF);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) asyncReset();
      else step(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 7)), {$urandom, $urandom},
                ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
